// File: rtl/tick_gen_multi_if.sv
// Control, configuration-write and tick signals for tick_gen_multi.
// The sq output exists only when TICK_GEN_SQ_EN is defined.
interface tick_gen_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] clr;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_period;
    logic              cfg_oneshot;
    logic              cfg_err;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] busy;
`ifdef TICK_GEN_SQ_EN
    logic [NUM_CH-1:0] sq;
`endif

    modport master (
        output en, clr, cfg_valid, cfg_ch, cfg_period, cfg_oneshot,
        input  cfg_ready, cfg_err, tick, busy
`ifdef TICK_GEN_SQ_EN
        , input sq
`endif
    );

    modport slave (
        input  en, clr, cfg_valid, cfg_ch, cfg_period, cfg_oneshot,
        output cfg_ready, cfg_err, tick, busy
`ifdef TICK_GEN_SQ_EN
        , output sq
`endif
    );
endinterface

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator, periodic or one-shot per channel.
// Define TICK_GEN_SQ_EN to add a per-channel square-wave output (sq).
module tick_gen_multi #(
    parameter int          NUM_CH     = 4,
    parameter int          CNT_W      = 32,
    parameter int unsigned DEF_PERIOD = 2500000
) (
    input logic             clk,
    input logic             rst,
    tick_gen_multi_if.slave bus
);
    localparam int               CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEF_PERIOD);

    typedef enum logic {
        CFG_OPEN,
        CFG_HOLD
    } cfg_state_t;

    cfg_state_t cfg_state;
    cfg_state_t cfg_state_nx;
    logic       cfg_ready;
    logic       accept;
    logic       ch_ok;
    logic       wr_ok;
    logic       cfg_err_q;

    // Ready is gated by rst so it drops during reset and is high on the first cycle after.
    assign cfg_ready     = ~rst & (cfg_state == CFG_OPEN);
    assign accept        = bus.cfg_valid & cfg_ready;
    assign ch_ok         = 32'(bus.cfg_ch) < 32'(NUM_CH);
    assign wr_ok         = accept & ch_ok;
    assign bus.cfg_ready = cfg_ready;
    assign bus.cfg_err   = cfg_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_state <= CFG_OPEN;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_state <= cfg_state_nx;
            cfg_err_q <= accept & ~ch_ok;
        end
    end

    always_comb begin
        cfg_state_nx = cfg_state;
        unique case (cfg_state)
            CFG_OPEN: if (accept) cfg_state_nx = CFG_HOLD;
            CFG_HOLD: cfg_state_nx = CFG_OPEN;
        endcase
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic             wr;
        logic             run;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_nx;
        logic [CNT_W-1:0] period_q;
        logic [CNT_W-1:0] period_nx;
        logic             oneshot_q;
        logic             oneshot_nx;
        logic             armed_q;
        logic             armed_nx;
        logic             en_q;
        logic             tick_q;
        logic             tick_nx;

        assign wr  = wr_ok & (bus.cfg_ch == CH_W'(g));
        assign run = bus.en[g] & (~oneshot_q | armed_q);

        // Priority: config write, then clear, then normal counting.
        always_comb begin
            cnt_nx     = cnt_q;
            period_nx  = period_q;
            oneshot_nx = oneshot_q;
            armed_nx   = armed_q;
            tick_nx    = 1'b0;
            if (wr) begin
                period_nx  = bus.cfg_period;
                oneshot_nx = bus.cfg_oneshot;
                armed_nx   = bus.cfg_oneshot;
                cnt_nx     = '0;
            end else if (bus.clr[g]) begin
                cnt_nx = '0;
            end else if (run) begin
                if (cnt_q == period_q) begin
                    cnt_nx   = '0;
                    tick_nx  = 1'b1;
                    armed_nx = 1'b0;
                end else begin
                    cnt_nx = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q     <= '0;
                period_q  <= RST_PERIOD;
                oneshot_q <= 1'b0;
                armed_q   <= 1'b0;
                en_q      <= 1'b0;
                tick_q    <= 1'b0;
            end else begin
                cnt_q     <= cnt_nx;
                period_q  <= period_nx;
                oneshot_q <= oneshot_nx;
                armed_q   <= armed_nx;
                en_q      <= bus.en[g];
                tick_q    <= tick_nx;
            end
        end

        assign bus.tick[g] = tick_q;
        assign bus.busy[g] = oneshot_q ? armed_q : en_q;

`ifdef TICK_GEN_SQ_EN
        logic sq_q;

        always_ff @(posedge clk) begin
            if (rst || wr || bus.clr[g]) begin
                sq_q <= 1'b0;
            end else begin
                sq_q <= sq_q ^ tick_nx;
            end
        end

        assign bus.sq[g] = sq_q;
`endif
    end
endmodule

// File: doc/tick_gen_multi.md
TICK_GEN_MULTI -- requirements
Module: tick_gen_multi

Interface
REQ-001 SHALL provide parameter NUM_CH, default 4, number of independent tick channels (1..16).
REQ-002 SHALL provide parameter CNT_W, default 32, counter/period width in bits.
REQ-003 SHALL provide parameter DEF_PERIOD, default 2500000, per-channel period loaded at reset.
REQ-004 SHALL provide port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL provide port en  input  NUM_CH  per-channel count enable.
REQ-007 SHALL provide port clr  input  NUM_CH  per-channel counter clear pulse.
REQ-008 SHALL provide port cfg_valid  input  1  configuration write request.
REQ-009 SHALL provide port cfg_ready  output  1  configuration write can be accepted.
REQ-010 SHALL provide port cfg_ch  input  max(1,$clog2(NUM_CH))  target channel index.
REQ-011 SHALL provide port cfg_period  input  CNT_W  new terminal count P.
REQ-012 SHALL provide port cfg_oneshot  input  1  new mode: 0 periodic, 1 one-shot.
REQ-013 SHALL provide port cfg_err  output  1  one-cycle pulse for an accepted write with cfg_ch >= NUM_CH.
REQ-014 SHALL provide port tick  output  NUM_CH  registered single-cycle pulses, one bit per channel.
REQ-015 SHALL provide port busy  output  NUM_CH  channel is actively counting.

Function
REQ-016 SHALL accept a write when cfg_valid && cfg_ready; cfg_ready SHALL be 0 for exactly the one cycle after an accepted write, else 1.
REQ-017 On acceptance of a valid cfg_ch, the next cycle SHALL load P and mode, clear that counter to 0, and suppress its tick that cycle.
REQ-018 An accepted write with cfg_ch >= NUM_CH SHALL change no state and pulse cfg_err the next cycle.
REQ-019 Periodic channel with en=1: counter increments each cycle; at count==P, tick=1 for one cycle and count returns to 0 (tick every P+1 cycles).
REQ-020 P=0 SHALL give tick=1 every cycle while enabled.
REQ-021 en=0 SHALL hold the counter value and force tick=0; counting resumes from the held value.
REQ-022 Periodic mode: busy SHALL equal the registered en bit.
REQ-023 One-shot mode: a write arms the channel (busy=1); with en=1 it counts to P, emits one tick, then busy=0 and count holds 0 until re-armed by another write.
REQ-024 clr SHALL set the counter to 0 next cycle, suppress the tick that cycle, and leave period, mode, and busy unchanged.
REQ-025 Simultaneous clr and terminal count: clr wins, no tick.
REQ-026 Simultaneous config write and clr on the same channel: the write wins (loads P and mode and clears).
REQ-027 Channels SHALL be fully independent; a write to one channel SHALL NOT disturb another's count.

Reset
REQ-028 While rst=1: all counters 0; periods DEF_PERIOD; mode periodic; tick 0; busy 0; cfg_err 0; cfg_ready 0.
REQ-029 The first cycle after rst deasserts, cfg_ready SHALL be 1.
REQ-030 Reset SHALL abort any in-progress count or one-shot without emitting a tick.

Configuration
REQ-031 Macro TICK_GEN_SQ_EN defined: SHALL add output sq [NUM_CH], with each bit toggling on every tick of its channel (square wave of period 2*(P+1)).
REQ-032 sq SHALL reset to 0 and be forced to 0 by clr or a config write to that channel.
REQ-033 Without TICK_GEN_SQ_EN: port sq and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-034 Reset, NUM_CH=4, write ch0 P=3 periodic, en=4'b0001 -> tick[0] on every 4th cycle; other ticks 0.
REQ-035 Write ch2 P=5 one-shot, en[2]=1 -> exactly one tick[2] 6 cycles after the load cycle; then busy[2]=0 and no further ticks for 50 cycles.
REQ-036 ch1 P=9, drop en[1] at count 4 for 10 cycles, then restore -> next tick[1] 5 enabled cycles later.
REQ-037 Assert clr[0] in the same cycle count==P -> no tick; next tick P+1 cycles later. Back-to-back cfg_valid -> second write accepted one cycle late (cfg_ready low one cycle).
REQ-038 Write cfg_ch=5 with NUM_CH=4 -> cfg_err pulses once; no tick timing changes. With TICK_GEN_SQ_EN, P=1 -> sq[0] period 4 cycles.
